// File: rtl/spad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spad_pkg
// Purpose  : Shared access-size encoding and lane helpers for banked_scratchpad
// Revision : 1.0
// ============================================================================
package spad_pkg;

    typedef enum logic [1:0] {
        LEN_B = 2'b00,
        LEN_H = 2'b01,
        LEN_W = 2'b10,
        LEN_D = 2'b11
    } len_e;

    function automatic logic [3:0] len_bytes(input logic [1:0] len);
        return 4'd1 << len;
    endfunction

    function automatic logic [7:0] byte_en(input logic [1:0] len, input logic [2:0] lane);
        logic [7:0] m;
        case (len_e'(len))
            LEN_B:   m = 8'h01;
            LEN_H:   m = 8'h03;
            LEN_W:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lane;
    endfunction

    // Shift the addressed bytes down to bit 0 and clear everything above the access size.
    function automatic logic [63:0] load_extract(input logic [63:0] row, input logic [1:0] len,
                                                 input logic [2:0] lane);
        logic [63:0] s;
        s = row >> {lane, 3'b000};
        case (len_e'(len))
            LEN_B:   return {56'd0, s[7:0]};
            LEN_H:   return {48'd0, s[15:0]};
            LEN_W:   return {32'd0, s[31:0]};
            default: return s;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spad_bank.sv
`default_nettype none
// ============================================================================
// Module   : spad_bank
// Purpose  : One 64-bit synchronous RAM bank, byte write enables, 1-cycle read
// Revision : 1.0
// ============================================================================
module spad_bank #(
    parameter int ROWS  = 16384,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  logic [7:0]       be,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem_q [ROWS];
    logic [63:0] rdata_q;

    // Contents are deliberately unreset; the read register only moves on a load.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) begin
                        mem_q[row][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[row];
            end
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/banked_scratchpad.sv
`default_nettype none
// ============================================================================
// Module   : banked_scratchpad
// Purpose  : Multi-port, word-interleaved scratchpad with per-bank RR arbiters
// Revision : 1.0
// ============================================================================
module banked_scratchpad
    import spad_pkg::*;
#(
    parameter int          CHUNK_SIZE      = 512,
    parameter int          NUM_CHUNKS      = 1024,
    parameter logic [63:0] SCRATCHPAD_BASE = 64'h0300000000000000,
    parameter int          NUM_PORTS       = 2,
    parameter int          NUM_BANKS       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    req_valid,
    output logic [NUM_PORTS-1:0]    req_ready,
    input  logic [NUM_PORTS-1:0]    req_write,
    input  logic [NUM_PORTS*64-1:0] req_addr,
    input  logic [NUM_PORTS*2-1:0]  req_len,
    input  logic [NUM_PORTS*64-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]    rsp_valid,
    output logic [NUM_PORTS-1:0]    rsp_err,
    output logic [NUM_PORTS*64-1:0] rsp_rdata
);

    localparam int          SIZE   = CHUNK_SIZE * NUM_CHUNKS;
    localparam logic [64:0] SIZE65 = 65'(SIZE);
    localparam int          LOG2B  = $clog2(NUM_BANKS);
    localparam int          BANK_W = (NUM_BANKS > 1) ? LOG2B : 1;
    localparam int          ROWS   = SIZE / (8 * NUM_BANKS);
    localparam int          ROW_W  = $clog2(ROWS);
    localparam int          PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]             valid_eff, legal, bad_req, port_gnt;
    logic [NUM_PORTS-1:0][2:0]        lane;
    logic [NUM_PORTS-1:0][BANK_W-1:0] bank_idx;
    logic [NUM_PORTS-1:0][ROW_W-1:0]  row_idx;

    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_gnt;
    logic [NUM_BANKS-1:0][63:0]          bank_rdata;

    // Per-port decode; the end offset is 65 bits so a huge offset cannot wrap into range.
    always_comb begin
        logic [63:0] addr, off;
        logic [64:0] end_off;
        logic [3:0]  nbytes;
        addr      = '0;
        off       = '0;
        end_off   = '0;
        nbytes    = '0;
        valid_eff = req_valid & {NUM_PORTS{rst_n}};
        legal     = '0;
        bad_req   = '0;
        lane      = '0;
        bank_idx  = '0;
        row_idx   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr        = req_addr[64*p +: 64];
            off         = addr - SCRATCHPAD_BASE;
            nbytes      = len_bytes(req_len[2*p +: 2]);
            end_off     = {1'b0, off} + {61'd0, nbytes};
            legal[p]    = (addr >= SCRATCHPAD_BASE) && (end_off <= SIZE65) &&
                          ((off[2:0] & (nbytes[2:0] - 3'd1)) == 3'd0);
            lane[p]     = off[2:0];
            bank_idx[p] = BANK_W'((off >> 3) & 64'(NUM_BANKS - 1));
            row_idx[p]  = ROW_W'(off >> (3 + LOG2B));
            bad_req[p]  = valid_eff[p] & ~legal[p];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [PTR_W-1:0]     ptr_q, ptr_d;
        logic [PTR_W-1:0]     win;
        logic                 hit;
        logic [NUM_PORTS-1:0] gnt;
        logic                 we_sel;
        logic [ROW_W-1:0]     row_sel;
        logic [7:0]           be_sel;
        logic [63:0]          wdata_sel;

        // Search from the pointer upward; the first legal requester for this bank wins.
        always_comb begin
            int idx;
            idx = 0;
            gnt = '0;
            win = '0;
            hit = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!hit && valid_eff[idx] && legal[idx] && (bank_idx[idx] == BANK_W'(b))) begin
                    hit      = 1'b1;
                    win      = PTR_W'(idx);
                    gnt[idx] = 1'b1;
                end
            end
            ptr_d = ptr_q;
            if (hit) begin
                ptr_d = (int'(win) == NUM_PORTS - 1) ? '0 : win + PTR_W'(1);
            end
            we_sel    = req_write[win];
            row_sel   = row_idx[win];
            be_sel    = byte_en(req_len[2*int'(win) +: 2], lane[win]);
            wdata_sel = req_wdata[64*int'(win) +: 64] << {lane[win], 3'b000};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        spad_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (hit),
            .we    (we_sel),
            .row   (row_sel),
            .be    (be_sel),
            .wdata (wdata_sel),
            .rdata (bank_rdata[b])
        );

        assign bank_gnt[b] = gnt;
    end

    always_comb begin
        port_gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            port_gnt = port_gnt | bank_gnt[b];
        end
    end

    // Illegal requests are accepted immediately and never reach a bank.
    assign req_ready = (bad_req | port_gnt) & {NUM_PORTS{rst_n}};

    logic [NUM_PORTS-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NUM_PORTS-1:0]             rsp_err_q, rsp_err_d;
    logic [NUM_PORTS-1:0]             ld_q, ld_d;
    logic [NUM_PORTS-1:0][2:0]        lane_q, lane_d;
    logic [NUM_PORTS-1:0][1:0]        len_q, len_d;
    logic [NUM_PORTS-1:0][BANK_W-1:0] bank_sel_q, bank_sel_d;

    always_comb begin
        rsp_valid_d = req_ready;
        rsp_err_d   = bad_req;
        ld_d        = port_gnt & ~req_write;
        lane_d      = lane;
        len_d       = req_len;
        bank_sel_d  = bank_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            ld_q        <= '0;
            lane_q      <= '0;
            len_q       <= '0;
            bank_sel_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ld_q        <= ld_d;
            lane_q      <= lane_d;
            len_q       <= len_d;
            bank_sel_q  <= bank_sel_d;
        end
    end

    // Load data is steered from the bank read register selected one cycle earlier.
    always_comb begin
        rsp_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ld_q[p]) begin
                rsp_rdata[64*p +: 64] = load_extract(bank_rdata[bank_sel_q[p]], len_q[p], lane_q[p]);
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_scratchpad.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_scratchpad
// Purpose  : Directed + randomized bench for banked_scratchpad with a byte-level model
// Revision : 1.0
// ============================================================================
module tb_banked_scratchpad;

    localparam int          NP   = 2;
    localparam int          NB   = 4;
    localparam logic [63:0] BASE = 64'h0300000000000000;
    localparam longint      SIZE = 512 * 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [NP-1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_err;
    logic [NP-1:0][63:0] req_addr, req_wdata, rsp_rdata;
    logic [NP-1:0][1:0]  req_len;

    always #5 clk = ~clk;

    banked_scratchpad dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]    mem_m [longint];
    int            ptr_m [NB];
    int            rsp_cnt [NP];
    logic [NP-1:0] last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input logic [63:0] a, input logic [1:0] l);
        logic [64:0] off;
        int nb;
        nb = 1 << l;
        if (a < BASE) return 1'b0;
        off = {1'b0, a - BASE};
        if (off + 65'(nb) > 65'(SIZE)) return 1'b0;
        return (off % 65'(nb)) == 65'd0;
    endfunction

    function automatic int m_bank(input logic [63:0] a);
        return int'(((a - BASE) >> 3) % 64'(NB));
    endfunction

    task automatic drive(input int p, input logic v, input logic w, input logic [1:0] l,
                         input logic [63:0] a, input logic [63:0] d);
        req_valid[p] = v;
        req_write[p] = w;
        req_len[p]   = l;
        req_addr[p]  = a;
        req_wdata[p] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_write = '0;
        req_len   = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // One cycle: predict acceptance and responses, check ready, then check responses.
    task automatic step();
        logic [NP-1:0] exp_rdy, exp_err;
        logic [63:0]   exp_data [NP];
        logic [63:0]   off;
        int            nb, p;
        bit            done;
        exp_rdy = '0;
        exp_err = '0;
        for (int q = 0; q < NP; q++) begin
            exp_data[q] = '0;
            if (req_valid[q] && !m_legal(req_addr[q], req_len[q])) begin
                exp_rdy[q] = 1'b1;
                exp_err[q] = 1'b1;
            end
        end
        for (int b = 0; b < NB; b++) begin
            done = 1'b0;
            for (int k = 0; k < NP; k++) begin
                p = (ptr_m[b] + k) % NP;
                if (!done && req_valid[p] && m_legal(req_addr[p], req_len[p]) &&
                    m_bank(req_addr[p]) == b) begin
                    done       = 1'b1;
                    exp_rdy[p] = 1'b1;
                    ptr_m[b]   = (p + 1) % NP;
                end
            end
        end
        for (int q = 0; q < NP; q++) begin
            if (exp_rdy[q] && !exp_err[q] && !req_write[q]) begin
                off = req_addr[q] - BASE;
                nb  = 1 << req_len[q];
                for (int i = 0; i < nb; i++) begin
                    exp_data[q][8*i +: 8] = mem_m[longint'(off + 64'(i))];
                end
            end
        end
        #1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        last_rdy = req_ready;
        @(posedge clk);
        for (int q = 0; q < NP; q++) begin
            if (exp_rdy[q] && !exp_err[q] && req_write[q]) begin
                off = req_addr[q] - BASE;
                nb  = 1 << req_len[q];
                for (int i = 0; i < nb; i++) begin
                    mem_m[longint'(off + 64'(i))] = req_wdata[q][8*i +: 8];
                end
            end
        end
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rdy));
        for (int q = 0; q < NP; q++) begin
            if (rsp_valid[q]) rsp_cnt[q]++;
            if (exp_rdy[q]) begin
                chk($sformatf("rsp_err%0d", q), 64'(rsp_err[q]), 64'(exp_err[q]));
                chk($sformatf("rsp_rdata%0d", q), rsp_rdata[q], exp_data[q]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  l;
        logic [63:0] a;
        int          kind;
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        for (int q = 0; q < NP; q++) rsp_cnt[q] = 0;
        idle();
        drive(0, 1'b1, 1'b0, 2'd3, BASE, 64'd0);
        drive(1, 1'b1, 1'b0, 2'd3, BASE + 64'h8, 64'd0);

        // Asynchronous reset, asserted between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Fill the first 256 bytes so every later load hits known data.
        for (int w = 0; w < 32; w += 2) begin
            drive(0, 1'b1, 1'b1, 2'd3, BASE + 64'(8 * w), {$urandom, $urandom});
            drive(1, 1'b1, 1'b1, 2'd3, BASE + 64'(8 * (w + 1)), {$urandom, $urandom});
            step();
        end
        idle();

        drive(0, 1'b1, 1'b1, 2'd3, BASE + 64'h10, 64'h1122334455667788);
        step();
        drive(0, 1'b1, 1'b0, 2'd3, BASE + 64'h10, 64'd0);
        step();
        chk("ld_double", rsp_rdata[0], 64'h1122334455667788);
        drive(0, 1'b1, 1'b1, 2'd0, BASE + 64'h13, 64'h00000000000000AB);
        step();
        drive(0, 1'b1, 1'b0, 2'd3, BASE + 64'h10, 64'd0);
        step();
        chk("ld_after_byte", rsp_rdata[0], 64'h11223344AB667788);
        drive(0, 1'b1, 1'b0, 2'd1, BASE + 64'h12, 64'd0);
        step();
        chk("ld_half", rsp_rdata[0], 64'h000000000000AB66);

        // Both ports on bank 1 for six cycles.
        for (int q = 0; q < NP; q++) rsp_cnt[q] = 0;
        drive(0, 1'b1, 1'b0, 2'd3, BASE + 64'h08, 64'd0);
        drive(1, 1'b1, 1'b0, 2'd3, BASE + 64'h28, 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("conflict_onehot", 64'($countones(last_rdy)), 64'd1);
        end
        chk("conflict_cnt0", 64'(rsp_cnt[0]), 64'd3);
        chk("conflict_cnt1", 64'(rsp_cnt[1]), 64'd3);

        // Different banks proceed together.
        drive(0, 1'b1, 1'b0, 2'd3, BASE + 64'h00, 64'd0);
        drive(1, 1'b1, 1'b0, 2'd3, BASE + 64'h08, 64'd0);
        step();
        chk("parallel_ready", 64'(last_rdy), 64'h3);
        idle();

        drive(0, 1'b1, 1'b0, 2'd3, BASE - 64'h8, 64'd0);
        step();
        chk("err_below", 64'(rsp_err[0]), 64'd1);
        drive(0, 1'b1, 1'b0, 2'd2, BASE + 64'h02, 64'd0);
        step();
        chk("err_misalign", 64'(rsp_err[0]), 64'd1);
        drive(0, 1'b1, 1'b1, 2'd3, BASE + 64'(SIZE - 8), 64'hCAFEF00DDEADBEEF);
        step();
        chk("top_store_ok", 64'(rsp_err[0]), 64'd0);
        drive(0, 1'b1, 1'b0, 2'd3, BASE + 64'(SIZE - 8), 64'd0);
        drive(1, 1'b1, 1'b0, 2'd3, BASE + 64'(SIZE), 64'd0);
        step();
        chk("top_load", rsp_rdata[0], 64'hCAFEF00DDEADBEEF);
        chk("err_end", 64'(rsp_err[1]), 64'd1);
        idle();

        // Randomized mix of legal and illegal traffic.
        for (int i = 0; i < 300; i++) begin
            for (int q = 0; q < NP; q++) begin
                l    = 2'($urandom_range(0, 3));
                kind = $urandom_range(0, 9);
                a    = BASE + (64'($urandom_range(0, 255)) & ~(64'(1 << l) - 64'd1));
                if (kind == 0) a = BASE - 64'(8 * $urandom_range(1, 4));
                if (kind == 1) a = BASE + 64'(SIZE) + 64'(8 * $urandom_range(0, 4));
                if (kind == 2 && l != 2'd0) a = a + 64'd1;
                drive(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l, a,
                      {$urandom, $urandom});
            end
            step();
        end
        idle();

        // Reset lands the cycle after a load handshake.
        drive(0, 1'b1, 1'b0, 2'd3, BASE + 64'h10, 64'd0);
        #1;
        chk("pre_rst_ready", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_err", 64'(rsp_err), 64'd0);
        chk("midrst_rdata", rsp_rdata, 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_valid2", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        idle();
        drive(0, 1'b1, 1'b0, 2'd3, BASE + 64'h00, 64'd0);
        drive(1, 1'b1, 1'b0, 2'd3, BASE + 64'h20, 64'd0);
        step();
        chk("post_rst_winner", 64'(last_rdy), 64'h1);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
